// File: rtl/ppu_video_timing.sv
// PPU raster timing and pixel output stage.
// Dot/line counters for the NTSC raster with odd-frame dot skip, vblank flag,
// frame pulse, and a fixed-depth pipeline carrying the renderer's palette index
// (greyscale-masked) out to the video sink during the visible window.
module ppu_video_timing #(
  parameter int DOTS     = 341,
  parameter int LINES    = 262,
  parameter int VIS_W    = 256,
  parameter int VIS_H    = 240,
  parameter int VBL_LINE = 241,
  parameter int PIPE     = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rendering_en_i,
  input  logic       greyscale_i,
  input  logic [5:0] pal_idx_i,
  output logic [8:0] dot_o,
  output logic [8:0] line_o,
  output logic [7:0] pixel_o,
  output logic       pixel_en_o,
  output logic       frame_o,
  output logic       vblank_o,
  output logic       odd_frame_o
);

  localparam logic [8:0] DOT_LAST  = 9'(DOTS - 1);
  localparam logic [8:0] DOT_SKIP  = 9'(DOTS - 2);
  localparam logic [8:0] LINE_LAST = 9'(LINES - 1);
  localparam logic [8:0] VIS_W_L   = 9'(VIS_W);
  localparam logic [8:0] VIS_H_L   = 9'(VIS_H);
  localparam logic [8:0] VBL_L     = 9'(VBL_LINE);

  logic [8:0] dot_q, dot_d;
  logic [8:0] line_q, line_d;
  logic       odd_q, odd_d;
  logic       frame_q, frame_d;
  logic       vblank_q, vblank_d;
  logic       visible;
  logic [5:0] idx_masked;

  logic [PIPE-1:0]      en_q;
  logic [PIPE-1:0][5:0] data_q;

  // Raster position advance, including the odd-frame skip of the last dot.
  always_comb begin
    dot_d  = dot_q + 9'd1;
    line_d = line_q;
    odd_d  = odd_q;
    if ((line_q == LINE_LAST) && (dot_q == DOT_SKIP) && odd_q && rendering_en_i) begin
      dot_d  = 9'd0;
      line_d = 9'd0;
      odd_d  = ~odd_q;
    end else if (dot_q == DOT_LAST) begin
      dot_d = 9'd0;
      if (line_q == LINE_LAST) begin
        line_d = 9'd0;
        odd_d  = ~odd_q;
      end else begin
        line_d = line_q + 9'd1;
      end
    end
  end

  // Frame pulse and vblank are decoded from the next position so they line up
  // exactly with the cycle in which that position is current.
  always_comb begin
    frame_d  = (line_d == LINE_LAST) && (dot_d == 9'd0);
    vblank_d = vblank_q;
    if ((line_d == VBL_L) && (dot_d == 9'd1)) begin
      vblank_d = 1'b1;
    end else if ((line_d == LINE_LAST) && (dot_d == 9'd1)) begin
      vblank_d = 1'b0;
    end
  end

  // Visible-window decode and greyscale masking of the current sample.
  always_comb begin
    visible    = (line_q < VIS_H_L) && (dot_q >= 9'd1) && (dot_q <= VIS_W_L);
    idx_masked = greyscale_i ? (pal_idx_i & 6'h30) : pal_idx_i;
  end

  // Counter, flag and frame-pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dot_q    <= 9'd0;
      line_q   <= 9'd0;
      odd_q    <= 1'b0;
      frame_q  <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      dot_q    <= dot_d;
      line_q   <= line_d;
      odd_q    <= odd_d;
      frame_q  <= frame_d;
      vblank_q <= vblank_d;
    end
  end

  // Pixel pipeline; blank slots carry zero data so pixel is 0 whenever not enabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q   <= '0;
      data_q <= '0;
    end else begin
      en_q[0]   <= visible;
      data_q[0] <= visible ? idx_masked : 6'd0;
      for (int i = 1; i < PIPE; i++) begin
        en_q[i]   <= en_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign dot_o       = dot_q;
  assign line_o      = line_q;
  assign odd_frame_o = odd_q;
  assign frame_o     = frame_q;
  assign vblank_o    = vblank_q;
  assign pixel_en_o  = en_q[PIPE-1];
  assign pixel_o     = {2'b00, data_q[PIPE-1]};

endmodule

// File: tb/tb_ppu_video_timing.sv
// Bench for ppu_video_timing on a scaled-down raster (20 dots x 12 lines,
// 8x6 visible, vblank on line 7, pipe depth 2) so many frames fit in a short run.
// Expected pixels are queued as stimulus is driven; a separate monitor pops and
// compares them whenever pixel_en is presented.
module tb_ppu_video_timing;
  localparam int DOTS     = 20;
  localparam int LINES    = 12;
  localparam int VIS_W    = 8;
  localparam int VIS_H    = 6;
  localparam int VBL_LINE = 7;
  localparam int PIPE     = 2;
  localparam int PIX_PER_FRAME = VIS_W * VIS_H; // 48
  localparam int FRAME_LONG    = DOTS * LINES;  // 240
  localparam int FRAME_SHORT   = DOTS * LINES - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rendering_en;
  logic       greyscale;
  logic [5:0] pal_idx;
  logic [8:0] dot_o, line_o;
  logic [7:0] pixel_o;
  logic       pixel_en_o, frame_o, vblank_o, odd_frame_o;

  ppu_video_timing #(
    .DOTS(DOTS), .LINES(LINES), .VIS_W(VIS_W), .VIS_H(VIS_H),
    .VBL_LINE(VBL_LINE), .PIPE(PIPE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rendering_en_i(rendering_en), .greyscale_i(greyscale),
    .pal_idx_i(pal_idx), .dot_o(dot_o), .line_o(line_o), .pixel_o(pixel_o),
    .pixel_en_o(pixel_en_o), .frame_o(frame_o), .vblank_o(vblank_o),
    .odd_frame_o(odd_frame_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb[$];

  int m_dot, m_line;
  bit m_odd;
  int cyc, last_frame_cyc;
  bit seen_frame, skipped;
  int pal_mode, gs_mode, en_mode;
  int en_cnt = 0;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at (%0d,%0d): got %0d expected %0d", name, m_line, m_dot, act, exp);
    end
  endtask

  task automatic model_reset();
    m_dot = 0; m_line = 0; m_odd = 0;
    cyc = 0; last_frame_cyc = 0; seen_frame = 0; skipped = 0;
    sb.delete();
  endtask

  // One dot: check outputs against the position model, drive inputs, queue expectations.
  task automatic step();
    bit exp_vb, exp_en, vis, dec;
    logic [5:0] p, e;
    check("dot", dot_o, m_dot);
    check("line", line_o, m_line);
    check("odd_frame", odd_frame_o, m_odd);
    exp_vb = (m_line == VBL_LINE && m_dot >= 1) || (m_line > VBL_LINE && m_line < LINES-1) ||
             (m_line == LINES-1 && m_dot == 0);
    check("vblank", vblank_o, exp_vb);
    check("frame", frame_o, (m_line == LINES-1 && m_dot == 0));
    exp_en = (m_line < VIS_H) && (m_dot >= 1+PIPE) && (m_dot <= VIS_W+PIPE);
    check("pixel_en", pixel_en_o, exp_en);
    if (pal_mode == 0 && gs_mode == 0 && m_line == 0 && m_dot == 1+PIPE)
      check("first_pixel_line0", pixel_o, 8'h01);
    if (frame_o) begin
      if (seen_frame) check("frame_period", cyc - last_frame_cyc, skipped ? FRAME_SHORT : FRAME_LONG);
      else check("first_frame_cycle", cyc, (LINES-1)*DOTS);
      seen_frame = 1; last_frame_cyc = cyc; skipped = 0;
    end

    dec = (m_line == LINES-1) && (m_dot == DOTS-2);
    case (en_mode)
      1: rendering_en = 1'b1;
      2: rendering_en = dec;
      3: rendering_en = !dec;
      default: rendering_en = 1'b0;
    endcase
    case (gs_mode)
      1: greyscale = 1'b1;
      2: greyscale = 1'($urandom_range(0, 1));
      default: greyscale = 1'b0;
    endcase
    p = (pal_mode == 0) ? 6'(m_dot ^ m_line) : 6'h2D;
    pal_idx = p;
    vis = (m_line < VIS_H) && (m_dot >= 1) && (m_dot <= VIS_W);
    if (vis) begin
      if (pal_mode == 1) e = greyscale ? 6'h20 : 6'h2D;
      else e = greyscale ? (p & 6'h30) : p;
      sb.push_back({2'b00, e});
    end

    @(posedge clk);
    if (dec && m_odd && rendering_en) begin
      m_dot = 0; m_line = 0; m_odd = !m_odd; skipped = 1;
    end else if (m_dot == DOTS-1) begin
      m_dot = 0;
      if (m_line == LINES-1) begin m_line = 0; m_odd = !m_odd; end
      else m_line = m_line + 1;
    end else begin
      m_dot = m_dot + 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_to(int l, int d, bit need_odd);
    int n = 0;
    while (!(m_line == l && m_dot == d && (!need_odd || m_odd))) begin
      if (n >= 1000) begin
        tests++; fails++;
        $display("FAIL run_to_timeout: at (%0d,%0d) wanted (%0d,%0d)", m_line, m_dot, l, d);
        return;
      end
      step();
      n++;
    end
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_dot"}, dot_o, 0);
    check({tag, "_line"}, line_o, 0);
    check({tag, "_pixel"}, pixel_o, 0);
    check({tag, "_pixel_en"}, pixel_en_o, 0);
    check({tag, "_frame"}, frame_o, 0);
    check({tag, "_vblank"}, vblank_o, 0);
    check({tag, "_odd_frame"}, odd_frame_o, 0);
  endtask

  // Monitor: pops the scoreboard on every presented pixel.
  always @(negedge clk) begin
    if (rst) begin
      en_cnt = 0;
    end else begin
      if (pixel_en_o) begin
        en_cnt++;
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_underflow: pixel %0h presented, expected none", pixel_o);
        end else begin
          check("pixel", pixel_o, sb.pop_front());
        end
      end else begin
        check("pixel_idle", pixel_o, 0);
      end
      if (frame_o) begin
        check("pixel_en_per_frame", en_cnt, PIX_PER_FRAME);
        en_cnt = 0;
      end
    end
  end

  initial begin
    rst = 1'b1; rendering_en = 1'b0; greyscale = 1'b0; pal_idx = 6'd0;
    pal_mode = 0; gs_mode = 0; en_mode = 0;
    m_dot = 0; m_line = 0; m_odd = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    model_reset();

    // Skip disabled: every frame full length.
    repeat (3*FRAME_LONG) step();
    run_to(8, 0, 0);

    // Skip enabled: alternating long/short frames.
    en_mode = 1;
    repeat (5*FRAME_LONG) step();
    run_to(8, 0, 0);

    // Enable only at / everywhere except the decision cycle.
    en_mode = 2;
    repeat (2*FRAME_LONG) step();
    en_mode = 3;
    repeat (2*FRAME_LONG) step();
    run_to(8, 0, 0);

    // Fixed index with greyscale on then off; then random per-dot greyscale.
    en_mode = 0; pal_mode = 1; gs_mode = 1;
    repeat (FRAME_LONG) step();
    run_to(8, 0, 0);
    gs_mode = 0;
    repeat (FRAME_LONG) step();
    run_to(8, 0, 0);
    pal_mode = 0; gs_mode = 2;
    repeat (2*FRAME_LONG) step();
    run_to(8, 0, 0);

    // Asynchronous reset mid-line during an odd frame with pixels in flight.
    gs_mode = 0; en_mode = 1;
    run_to(4, 5, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2*FRAME_LONG) step();
    run_to(8, 0, 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ppu_video_timing.md
# ppu_video_timing

Synthesizable PPU raster timing and pixel output stage. Runs dot/scanline counters for the NTSC 341×262 raster and samples the renderer's 6-bit palette index during the 256×240 visible window. It drives the pixel/pixel_en/frame stream consumed by the video capture sink. It also provides the vblank flag, raster position and odd-frame dot skip to the rest of the PPU.

## Interface
- DOTS, 341: dots per scanline.
- LINES, 262: scanlines per frame.
- VIS_W, 256: visible dots, at dot 1..VIS_W.
- VIS_H, 240: visible lines, at line 0..VIS_H-1.
- VBL_LINE, 241: line on which vblank sets.
- PIPE, 2: pixel pipeline depth in cycles, minimum 1.

- clk, in, 1: pixel (dot) clock.
- rst, in, 1: asynchronous, active-high reset.
- rendering_en, in, 1: PPUMASK background-or-sprite enable; gates the odd-frame skip.
- greyscale, in, 1: PPUMASK greyscale; masks the index to pal_idx & 6'h30.
- pal_idx, in, 6: renderer palette index for the current dot.
- dot, out, 9: current dot, 0..DOTS-1.
- line, out, 9: current scanline, 0..LINES-1.
- pixel, out, 8: {2'b00, masked index}, delayed PIPE cycles.
- pixel_en, out, 1: pixel is valid; exactly VIS_W×VIS_H assertions per frame.
- frame, out, 1: one-cycle pulse at line LINES-1 (pre-render), dot 0.
- vblank, out, 1: vblank status flag.
- odd_frame, out, 1: parity of the current frame.

## Operation
- Counters:
  - dot increments every clk.
  - At dot DOTS-1, dot goes to 0 and line increments.
  - At line LINES-1, dot DOTS-1, line goes to 0 and odd_frame toggles.
- Odd-frame skip:
  - Condition: line==LINES-1, dot==DOTS-2, odd_frame==1, and rendering_en==1, all sampled in that cycle.
  - Next state: dot=0, line=0, odd_frame toggles.
  - Net effect: dot DOTS-1 is skipped and that frame is 1 dot shorter.
- visible = (line < VIS_H) && (dot >= 1) && (dot <= VIS_W). Combinational from the current counters; internal only.
- Pixel pipeline:
  - Stage 0 captures {visible, greyscale ? pal_idx & 6'h30 : pal_idx}.
  - The capture shifts through PIPE registers.
  - pixel_en and pixel are the last stage.
  - Invisible slots still shift, with en=0 and data=0, so pixel stays 0 whenever pixel_en=0.
- frame: registered, asserted for the one cycle where (line,dot)==(LINES-1,0) is the current position. This gives the consumer ≥340 cycles before the first pixel_en.
- vblank:
  - Set when (line,dot) becomes (VBL_LINE,1).
  - Cleared when (line,dot) becomes (LINES-1,1).
  - Held otherwise.
- No stall or back-pressure. The consumer must accept pixels at dot rate.

## Timing
- Reset values:
  - dot=0, line=0, odd_frame=0, vblank=0, frame=0, pixel_en=0, pixel=0.
  - All pipeline stages are cleared.
- Reset is asynchronous; deassertion takes effect at the next clk edge.
- Reset mid-line discards in-flight pipeline pixels. No pixel_en appears until PIPE cycles after the first visible dot following reset.
- Latency: pal_idx sampled at position (L,D) appears on pixel with pixel_en=1 exactly PIPE cycles later.
- pixel_en pattern per visible line:
  - First rises PIPE cycles after the line's dot 1.
  - Stays high for VIS_W contiguous cycles.
- Per-frame cycle counts:
  - Even frame, or rendering_en=0: DOTS×LINES = 89342.
  - Odd frame with rendering_en=1: 89341.
- rendering_en changes are honoured exactly at the skip-decision cycle. There is no earlier latch.
- Greyscale changes affect the pixel sampled in the same cycle.

## Test plan
- Reset deasserted, rendering_en=0:
  - frame first pulses at cycle 261×341 = 89001.
  - The next frame pulse comes 89342 cycles later.
  - Exactly 61440 pixel_en assertions occur between consecutive frame pulses.
- rendering_en=1:
  - The frame-to-frame period alternates 89342 / 89341.
  - odd_frame toggles at every frame wrap.
  - The short frame never shows dot 340 on line 261.
- Drive pal_idx = dot[5:0] ^ line[5:0], greyscale=0:
  - Every pixel matches the index sampled PIPE=2 cycles earlier.
  - The first pixel of line 0 is 6'h01, with pixel_en rising at line 0, dot 3.
- greyscale=1, pal_idx=6'h2D: pixel = 8'h20. With greyscale=0: 8'h2D.
- vblank:
  - Rises when (line,dot) is (241,1) and falls when (line,dot) is (261,1).
  - It is 0 throughout lines 0–240.
- Assert rst asynchronously at line 100, dot 50, for 3 cycles:
  - All outputs are 0 immediately, with no clk edge needed.
  - After release, counting restarts from (0,0).
  - No stale pixel_en appears.
